// File: rtl/hex_scan_display.sv
// Hex display driver: latched DIGITS-nibble value shown on static per-digit segment buses
// and on a scanned segment/anode pair. Optional macro HEX_SCAN_LEADING_ZERO_BLANK_EN.
module hex_scan_display #(
    parameter int DIGITS       = 8,
    parameter int PRESCALE     = 1000,
    parameter int BLANK_CYCLES = 0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   value,
    output logic [7*DIGITS-1:0]   segs_all,
    output logic [6:0]            seg_scan,
    output logic [DIGITS-1:0]     an,
    output logic                  frame_done
);

    localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int CNT_W = $clog2(PRESCALE);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(PRESCALE - 1);

    function automatic logic [6:0] hex_decode(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

    logic [4*DIGITS-1:0] shadow_p0;
    logic [CNT_W-1:0]    cnt_p0;
    logic [IDX_W-1:0]    idx_p0;
    logic                wrap_p0;

    logic [DIGITS-1:0]   show;
    logic [7*DIGITS-1:0] segs_dec;
    logic [3:0]          nib_sel;
    logic [6:0]          scan_dec;
    logic                blank_slot;
    logic                slot_wrap;

`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
    // A digit is shown when it or any more significant nibble is nonzero.
    always_comb begin
        logic above;
        above = 1'b0;
        show  = '0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            above   = above | (|shadow_p0[4*k +: 4]);
            show[k] = above;
        end
        show[0] = 1'b1;
    end
`else
    assign show = '1;
`endif

    always_comb begin
        segs_dec = '0;
        for (int k = 0; k < DIGITS; k++) begin
            segs_dec[7*k +: 7] = show[k] ? hex_decode(shadow_p0[4*k +: 4]) : 7'h7F;
        end
    end

    assign nib_sel    = shadow_p0[4*idx_p0 +: 4];
    assign scan_dec   = show[idx_p0] ? hex_decode(nib_sel) : 7'h7F;
    assign blank_slot = int'(cnt_p0) < BLANK_CYCLES;
    assign slot_wrap  = (cnt_p0 == CNT_LAST);

    // p0: shadow/prescaler/index state -> registered display outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            shadow_p0  <= '0;
            cnt_p0     <= '0;
            idx_p0     <= '0;
            wrap_p0    <= 1'b0;
            segs_all   <= '1;
            seg_scan   <= 7'h7F;
            an         <= '1;
            frame_done <= 1'b0;
        end else begin
            if (load) begin
                shadow_p0 <= value;
            end
            cnt_p0 <= slot_wrap ? '0 : cnt_p0 + 1'b1;
            if (slot_wrap) begin
                idx_p0 <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + 1'b1;
            end
            // frame_done lands one edge later, when an first shows digit 0 again
            wrap_p0    <= slot_wrap && (idx_p0 == IDX_LAST);
            frame_done <= wrap_p0;
            segs_all   <= segs_dec;
            seg_scan   <= blank_slot ? 7'h7F : scan_dec;
            an         <= ~(DIGITS'(1) << idx_p0);
        end
    end

endmodule

// File: tb/tb_hex_scan_display.sv
// Scoreboard bench for hex_scan_display: three instances (8 digits, 8 digits with
// anti-ghost blanking, 1 digit) driven from shared stimulus.
module tb_hex_scan_display;

`ifdef HEX_SCAN_LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        load;
    logic [31:0] value;

    logic [55:0] a_segs;
    logic [6:0]  a_scan;
    logic [7:0]  a_an;
    logic        a_fd;
    logic [55:0] b_segs;
    logic [6:0]  b_scan;
    logic [7:0]  b_an;
    logic        b_fd;
    logic [6:0]  c_segs;
    logic [6:0]  c_scan;
    logic [0:0]  c_an;
    logic        c_fd;

    hex_scan_display #(.DIGITS(8), .PRESCALE(4), .BLANK_CYCLES(0)) dut_a (
        .clk(clk), .rst(rst), .load(load), .value(value),
        .segs_all(a_segs), .seg_scan(a_scan), .an(a_an), .frame_done(a_fd)
    );

    hex_scan_display #(.DIGITS(8), .PRESCALE(4), .BLANK_CYCLES(1)) dut_b (
        .clk(clk), .rst(rst), .load(load), .value(value),
        .segs_all(b_segs), .seg_scan(b_scan), .an(b_an), .frame_done(b_fd)
    );

    hex_scan_display #(.DIGITS(1), .PRESCALE(3), .BLANK_CYCLES(0)) dut_c (
        .clk(clk), .rst(rst), .load(load), .value(value[3:0]),
        .segs_all(c_segs), .seg_scan(c_scan), .an(c_an), .frame_done(c_fd)
    );

    localparam int A_SEGS = 0, A_SCAN = 1, A_AN = 2, A_FD = 3;
    localparam int B_SEGS = 4, B_SCAN = 5, B_AN = 6, B_FD = 7;
    localparam int C_SEGS = 8, C_SCAN = 9, C_AN = 10, C_FD = 11;

    typedef struct {
        longint      t;
        int          sel;
        logic [63:0] exp;
    } exp_t;

    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   e;
    logic [31:0] sh;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [6:0] dec7(input logic [3:0] n);
        logic [6:0] t [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                               7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[n];
    endfunction

    function automatic int msd(input logic [31:0] v);
        int m = 0;
        for (int k = 0; k < 8; k++) if (v[4*k +: 4] != 4'h0) m = k;
        return m;
    endfunction

    function automatic logic [6:0] digit(input logic [31:0] v, input int k);
        return (LZB && k > msd(v)) ? 7'h7F : dec7(v[4*k +: 4]);
    endfunction

    function automatic logic [55:0] segs8(input logic [31:0] v);
        logic [55:0] r;
        for (int k = 0; k < 8; k++) r[7*k +: 7] = digit(v, k);
        return r;
    endfunction

    function automatic string sname(input int s);
        case (s)
            A_SEGS: return "a_segs_all";
            A_SCAN: return "a_seg_scan";
            A_AN:   return "a_an";
            A_FD:   return "a_frame_done";
            B_SEGS: return "b_segs_all";
            B_SCAN: return "b_seg_scan";
            B_AN:   return "b_an";
            B_FD:   return "b_frame_done";
            C_SEGS: return "c_segs_all";
            C_SCAN: return "c_seg_scan";
            C_AN:   return "c_an";
            default: return "c_frame_done";
        endcase
    endfunction

    function automatic logic [63:0] actual(input int s);
        case (s)
            A_SEGS: return 64'(a_segs);
            A_SCAN: return 64'(a_scan);
            A_AN:   return 64'(a_an);
            A_FD:   return 64'(a_fd);
            B_SEGS: return 64'(b_segs);
            B_SCAN: return 64'(b_scan);
            B_AN:   return 64'(b_an);
            B_FD:   return 64'(b_fd);
            C_SEGS: return 64'(c_segs);
            C_SCAN: return 64'(c_scan);
            C_AN:   return 64'(c_an);
            default: return 64'(c_fd);
        endcase
    endfunction

    // Expectation for the outputs visible at the coming falling edge.
    task automatic push(input int sel, input logic [63:0] ex);
        exp_t x;
        x.t   = (longint'($time) / 10 + 1) * 10;
        x.sel = sel;
        x.exp = ex;
        sbq.push_back(x);
    endtask

    initial begin
        exp_t x;
        logic [63:0] got;
        forever begin
            @(negedge clk);
            while (sbq.size() > 0 && sbq[0].t <= longint'($time)) begin
                x = sbq.pop_front();
                total++;
                got = actual(x.sel);
                if (x.t < longint'($time)) begin
                    bad++;
                    $display("FAIL %s stale entry t=%0d now=%0t", sname(x.sel), x.t, $time);
                end else if (got !== x.exp) begin
                    bad++;
                    $display("FAIL %s t=%0t got=%h want=%h", sname(x.sel), $time, got, x.exp);
                end
            end
        end
    end

    task automatic step(input bit ld, input logic [31:0] v);
        int          cnt;
        int          idx;
        logic [6:0]  dg;
        logic [6:0]  bs;
        logic [7:0]  an8;
        logic        fd8;
        logic        fd1;
        load  = ld;
        value = v;
        @(posedge clk);
        #1;
        load = 1'b0;
        if (rst) begin
            e  = 0;
            sh = 32'h0;
            push(A_SEGS, 64'({8{7'h7F}}));
            push(A_SCAN, 64'h7F);
            push(A_AN,   64'hFF);
            push(A_FD,   64'h0);
            push(B_SEGS, 64'({8{7'h7F}}));
            push(B_SCAN, 64'h7F);
            push(B_AN,   64'hFF);
            push(B_FD,   64'h0);
            push(C_SEGS, 64'h7F);
            push(C_SCAN, 64'h7F);
            push(C_AN,   64'h1);
            push(C_FD,   64'h0);
        end else begin
            e++;
            cnt = (e - 1) % 4;
            idx = ((e - 1) / 4) % 8;
            dg  = digit(sh, idx);
            bs  = (cnt == 0) ? 7'h7F : dg;
            an8 = ~(8'd1 << idx);
            fd8 = (e > 1) && ((e - 1) % 32 == 0);
            fd1 = (e > 1) && ((e - 1) % 3 == 0);
            push(A_SEGS, 64'(segs8(sh)));
            push(A_SCAN, 64'(dg));
            push(A_AN,   64'(an8));
            push(A_FD,   64'(fd8));
            push(B_SEGS, 64'(segs8(sh)));
            push(B_SCAN, 64'(bs));
            push(B_AN,   64'(an8));
            push(B_FD,   64'(fd8));
            push(C_SEGS, 64'(dec7(sh[3:0])));
            push(C_SCAN, 64'(dec7(sh[3:0])));
            push(C_AN,   64'h0);
            push(C_FD,   64'(fd1));
            if (ld) sh = v;
        end
    endtask

    initial begin
        logic [55:0] want;
        rst   = 1'b1;
        load  = 1'b0;
        value = 32'h0;
        e     = 0;
        sh    = 32'h0;
        repeat (3) step(1'b0, 32'h0);
        rst = 1'b0;
        step(1'b0, 32'h0);

        step(1'b1, 32'hFF9FF06F);
        step(1'b0, 32'h0);
        want = {7'h0E, 7'h0E, 7'h10, 7'h0E, 7'h0E, 7'h40, 7'h02, 7'h0E};
        push(A_SEGS, 64'(want));

        repeat (43) step(1'b0, 32'h0);
        step(1'b1, 32'h0);
        step(1'b0, 32'h0);
        push(A_AN,   64'hF7);
        push(A_SCAN, LZB ? 64'h7F : 64'h40);

        repeat ($urandom_range(3, 12)) step(1'b0, 32'h0);
        rst = 1'b1;
        step(1'b0, 32'h0);
        rst = 1'b0;
        repeat (40) step(1'b0, 32'h0);

        step(1'b1, 32'h00000A05);
        step(1'b0, 32'h0);
        want = LZB ? {{5{7'h7F}}, 7'h08, 7'h40, 7'h12} : {{5{7'h40}}, 7'h08, 7'h40, 7'h12};
        push(A_SEGS, 64'(want));
        step(1'b1, 32'h0);
        step(1'b0, 32'h0);
        want = LZB ? {{7{7'h7F}}, 7'h40} : {8{7'h40}};
        push(A_SEGS, 64'(want));
        repeat (3) step(1'b0, 32'h0);

        repeat (3) @(negedge clk);
        #1;
        total++;
        if (sbq.size() != 0) begin
            bad++;
            $display("FAIL drain pending=%0d want=0", sbq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
